// File: rtl/elevador_pkg.sv
// rtl/elevador_pkg.sv - shared request codes, floor mapping and arbiter state encoding
package elevador_pkg;

    localparam int NUM_CODIGOS = 10;

    // Request codes presented on memoria; P1 is the ground floor (floor 0)
    localparam logic [3:0] COD_NADA      = 4'd0;
    localparam logic [3:0] COD_P1_CABINA = 4'd1;
    localparam logic [3:0] COD_P2_CABINA = 4'd2;
    localparam logic [3:0] COD_P3_CABINA = 4'd3;
    localparam logic [3:0] COD_P4_CABINA = 4'd4;
    localparam logic [3:0] COD_P1_SUBIR  = 4'd5;
    localparam logic [3:0] COD_P2_BAJAR  = 4'd6;
    localparam logic [3:0] COD_P2_SUBIR  = 4'd7;
    localparam logic [3:0] COD_P3_BAJAR  = 4'd8;
    localparam logic [3:0] COD_P3_SUBIR  = 4'd9;
    localparam logic [3:0] COD_P4_BAJAR  = 4'd10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVING = 2'd1,
        DWELL   = 2'd2
    } estado_t;

    // Floor a request code is served at
    function automatic logic [1:0] piso_de_codigo(input logic [3:0] codigo);
        case (codigo)
            COD_P1_CABINA, COD_P1_SUBIR:               return 2'd0;
            COD_P2_CABINA, COD_P2_BAJAR, COD_P2_SUBIR: return 2'd1;
            COD_P3_CABINA, COD_P3_BAJAR, COD_P3_SUBIR: return 2'd2;
            COD_P4_CABINA, COD_P4_BAJAR:               return 2'd3;
            default:                                   return 2'd0;
        endcase
    endfunction

    // Pending-vector mask of every code served at the given floor (bit k-1 = code k)
    function automatic logic [NUM_CODIGOS-1:0] mascara_piso(input logic [1:0] piso);
        logic [NUM_CODIGOS-1:0] m;
        m = '0;
        for (int k = 1; k <= NUM_CODIGOS; k++) begin
            if (piso_de_codigo(4'(k)) == piso) begin
                m[k-1] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/selector_circular.sv
// rtl/selector_circular.sv - round-robin pick of the first pending code after the pointer
module selector_circular
    import elevador_pkg::*;
(
    input  logic [NUM_CODIGOS-1:0] pedidos,
    input  logic [3:0]             ptr,
    output logic [3:0]             codigo,
    output logic                   valido
);

    logic [4:0] idx;

    // Walk codes ptr+1 .. ptr+10, wrapping 10 -> 1, and keep the first one pending
    always_comb begin
        codigo = COD_NADA;
        valido = 1'b0;
        idx    = '0;
        for (int i = 1; i <= NUM_CODIGOS; i++) begin
            idx = {1'b0, ptr} + 5'(i);
            if (idx > 5'(NUM_CODIGOS)) begin
                idx = idx - 5'(NUM_CODIGOS);
            end
            if (!valido && pedidos[4'(idx - 5'd1)]) begin
                codigo = idx[3:0];
                valido = 1'b1;
            end
        end
    end

endmodule

// File: rtl/memoria_pedidos.sv
// rtl/memoria_pedidos.sv - elevator request memory, round-robin arbiter and door dwell timer
module memoria_pedidos
    import elevador_pkg::*;
#(
    parameter int DOOR_CYCLES = 4,
    parameter int CNT_W       = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [3:0]             btn_cabina,
    input  logic [2:0]             btn_subir,
    input  logic [2:0]             btn_bajar,
    input  logic [1:0]             piso,
    input  logic                   puertas,
    output logic [3:0]             memoria,
    output logic [NUM_CODIGOS-1:0] pendientes,
    output logic                   ocupado
);

    // Buttons rearranged in code order: bit k-1 is the button that raises code k
    logic [NUM_CODIGOS-1:0] botones;
    logic [NUM_CODIGOS-1:0] botones_prev;
    logic [NUM_CODIGOS-1:0] flancos;
    logic [NUM_CODIGOS-1:0] mascara_limpia;

    estado_t          estado;
    logic [3:0]       objetivo;
    logic [3:0]       ptr;
    logic [CNT_W-1:0] contador;

    logic [3:0] sel_codigo;
    logic       sel_valido;
    logic       limpiar;

    assign botones = {btn_bajar[2], btn_subir[2], btn_bajar[1], btn_subir[1],
                      btn_bajar[0], btn_subir[0], btn_cabina};
    assign flancos = botones & ~botones_prev;

    // The last enabled dwell cycle retires every request for the served floor
    assign limpiar        = en && (estado == DWELL) && (contador == '0);
    assign mascara_limpia = limpiar ? mascara_piso(piso_de_codigo(objetivo)) : '0;

    selector_circular u_selector (
        .pedidos (pendientes),
        .ptr     (ptr),
        .codigo  (sel_codigo),
        .valido  (sel_valido)
    );

    // Button capture runs regardless of en; a clear on the same cycle beats a new edge
    always_ff @(posedge clk) begin
        if (rst) begin
            botones_prev <= '0;
            pendientes   <= '0;
        end else begin
            botones_prev <= botones;
            pendientes   <= (pendientes | flancos) & ~mascara_limpia;
        end
    end

    // Arbiter FSM: pick a target, wait for doors open at its floor, hold for the dwell, release
    always_ff @(posedge clk) begin
        if (rst) begin
            estado   <= IDLE;
            objetivo <= COD_NADA;
            ptr      <= COD_NADA;
            contador <= '0;
            memoria  <= COD_NADA;
            ocupado  <= 1'b0;
        end else if (en) begin
            case (estado)
                IDLE: begin
                    memoria <= COD_NADA;
                    ocupado <= 1'b0;
                    if (sel_valido) begin
                        objetivo <= sel_codigo;
                        memoria  <= sel_codigo;
                        ocupado  <= 1'b1;
                        estado   <= SERVING;
                    end
                end
                SERVING: begin
                    if (puertas && (piso == piso_de_codigo(objetivo))) begin
                        contador <= CNT_W'(DOOR_CYCLES - 1);
                        estado   <= DWELL;
                    end
                end
                DWELL: begin
                    if (contador == '0) begin
                        ptr     <= objetivo;
                        memoria <= COD_NADA;
                        ocupado <= 1'b0;
                        estado  <= IDLE;
                    end else begin
                        contador <= contador - CNT_W'(1);
                    end
                end
                default: begin
                    memoria <= COD_NADA;
                    ocupado <= 1'b0;
                    estado  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memoria_pedidos.sv
// tb/tb_memoria_pedidos.sv - self-checking bench for memoria_pedidos
module tb_memoria_pedidos;

    localparam int DOOR_CYCLES = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] btn_cabina;
    logic [2:0] btn_subir;
    logic [2:0] btn_bajar;
    logic [1:0] piso;
    logic       puertas;
    logic [3:0] memoria;
    logic [9:0] pendientes;
    logic       ocupado;

    int checks = 0;
    int errors = 0;

    memoria_pedidos #(.DOOR_CYCLES(DOOR_CYCLES), .CNT_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .btn_cabina (btn_cabina),
        .btn_subir  (btn_subir),
        .btn_bajar  (btn_bajar),
        .piso       (piso),
        .puertas    (puertas),
        .memoria    (memoria),
        .pendientes (pendientes),
        .ocupado    (ocupado)
    );

    always #5 clk = ~clk;

    // Reference model: pending set indexed by code, plus service bookkeeping
    logic [10:1] m_pend;
    logic [9:0]  m_prev;
    bit          m_busy;
    bit          m_dwell;
    int          m_target;
    int          m_left;
    int          m_ptr;
    int          m_mem;

    function automatic int floor_of(input int c);
        if (c <= 4) return c - 1;
        return (c - 4) / 2;
    endfunction

    function automatic logic [9:0] btn_vec(input logic [3:0] c, input logic [2:0] s, input logic [2:0] b);
        logic [9:0] v;
        v[3:0] = c;
        for (int f = 0; f < 3; f++) begin
            v[4 + 2*f] = s[f];
            v[5 + 2*f] = b[f];
        end
        return v;
    endfunction

    task automatic model_step();
        logic [9:0] b;
        logic [9:0] edges;
        int         cleared_floor;
        b = btn_vec(btn_cabina, btn_subir, btn_bajar);
        if (rst) begin
            m_pend = '0; m_prev = '0; m_busy = 0; m_dwell = 0;
            m_target = 0; m_left = 0; m_ptr = 0; m_mem = 0;
            return;
        end
        edges = b & ~m_prev;
        m_prev = b;
        cleared_floor = -1;
        if (en) begin
            if (!m_busy) begin
                if (m_pend != '0) begin
                    for (int i = 1; i <= 10; i++) begin
                        int c;
                        c = (m_ptr + i - 1) % 10 + 1;
                        if (m_pend[c]) begin
                            m_target = c;
                            break;
                        end
                    end
                    m_busy = 1;
                    m_mem = m_target;
                end
            end else if (!m_dwell) begin
                if (puertas && int'(piso) == floor_of(m_target)) begin
                    m_dwell = 1;
                    m_left = DOOR_CYCLES;
                end
            end else begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    cleared_floor = floor_of(m_target);
                    m_ptr = m_target;
                    m_busy = 0;
                    m_dwell = 0;
                    m_mem = 0;
                end
            end
        end
        for (int k = 1; k <= 10; k++) begin
            if (edges[k-1]) m_pend[k] = 1'b1;
            if (floor_of(k) == cleared_floor) m_pend[k] = 1'b0;
        end
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check("model_memoria", 16'(memoria), 16'(m_mem));
        check("model_pendientes", 16'(pendientes), 16'(m_pend));
        check("model_ocupado", 16'(ocupado), 16'(m_busy));
    endtask

    task automatic run_until_free(input string name);
        int n;
        n = 0;
        while (m_busy && n < 30) begin
            step();
            n++;
        end
        checks++;
        if (m_busy) begin
            errors++;
            $display("FAIL %s: service still busy after %0d cycles, expected free", name, n);
        end
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] cab;
        logic [1:0] piso;
        logic       pu;
        logic [3:0] mem;
        logic [9:0] pend;
        logic       ocu;
    } vec_t;

    vec_t tabla[17];

    initial begin
        int n;
        rst = 1'b1; en = 1'b1; btn_cabina = '0; btn_subir = '0; btn_bajar = '0;
        piso = 2'd0; puertas = 1'b0;

        // Reset with a held button, then a full service of cabin floor 1 and cabin floor 2
        tabla[0]  = '{1'b1, 4'b0010, 2'd0, 1'b0, 4'd0, 10'h000, 1'b0};
        tabla[1]  = '{1'b1, 4'b0010, 2'd0, 1'b0, 4'd0, 10'h000, 1'b0};
        tabla[2]  = '{1'b0, 4'b0010, 2'd0, 1'b0, 4'd0, 10'h002, 1'b0};
        tabla[3]  = '{1'b0, 4'b0010, 2'd0, 1'b0, 4'd2, 10'h002, 1'b1};
        tabla[4]  = '{1'b0, 4'b0000, 2'd1, 1'b1, 4'd2, 10'h002, 1'b1};
        tabla[5]  = '{1'b0, 4'b0000, 2'd1, 1'b1, 4'd2, 10'h002, 1'b1};
        tabla[6]  = '{1'b0, 4'b0000, 2'd1, 1'b1, 4'd2, 10'h002, 1'b1};
        tabla[7]  = '{1'b0, 4'b0000, 2'd1, 1'b1, 4'd2, 10'h002, 1'b1};
        tabla[8]  = '{1'b0, 4'b0000, 2'd1, 1'b1, 4'd0, 10'h000, 1'b0};
        tabla[9]  = '{1'b0, 4'b0100, 2'd0, 1'b0, 4'd0, 10'h004, 1'b0};
        tabla[10] = '{1'b0, 4'b0000, 2'd0, 1'b0, 4'd3, 10'h004, 1'b1};
        tabla[11] = '{1'b0, 4'b0000, 2'd2, 1'b1, 4'd3, 10'h004, 1'b1};
        tabla[12] = '{1'b0, 4'b0000, 2'd2, 1'b1, 4'd3, 10'h004, 1'b1};
        tabla[13] = '{1'b0, 4'b0000, 2'd2, 1'b1, 4'd3, 10'h004, 1'b1};
        tabla[14] = '{1'b0, 4'b0000, 2'd2, 1'b1, 4'd3, 10'h004, 1'b1};
        tabla[15] = '{1'b0, 4'b0000, 2'd2, 1'b1, 4'd0, 10'h000, 1'b0};
        tabla[16] = '{1'b0, 4'b0000, 2'd0, 1'b0, 4'd0, 10'h000, 1'b0};

        for (int i = 0; i < 17; i++) begin
            rst = tabla[i].rst; btn_cabina = tabla[i].cab;
            piso = tabla[i].piso; puertas = tabla[i].pu;
            step();
            check($sformatf("tabla%0d_memoria", i), 16'(memoria), 16'(tabla[i].mem));
            check($sformatf("tabla%0d_pendientes", i), 16'(pendientes), 16'(tabla[i].pend));
            check($sformatf("tabla%0d_ocupado", i), 16'(ocupado), 16'(tabla[i].ocu));
        end

        // Codes 2, 6, 9 pending with ptr=0: serve 2 (clears 6 too), then 9
        rst = 1'b1; step(); rst = 1'b0;
        en = 1'b0; btn_cabina = 4'b0010; btn_bajar = 3'b001; btn_subir = 3'b100; step();
        btn_cabina = '0; btn_bajar = '0; btn_subir = '0; step();
        check("rr_pend_inicial", 16'(pendientes), 16'h122);
        en = 1'b1; step();
        check("rr_primero", 16'(memoria), 16'd2);
        piso = 2'd1; puertas = 1'b1;
        run_until_free("rr_servicio2");
        check("rr_pend_tras_2", 16'(pendientes), 16'h100);
        step();
        check("rr_segundo", 16'(memoria), 16'd9);
        piso = 2'd2;
        run_until_free("rr_servicio9");
        check("rr_pend_final", 16'(pendientes), 16'h000);

        // Presses landing exactly on the clear cycle of code 7
        puertas = 1'b0; btn_subir = 3'b010; step();
        btn_subir = 3'b000; step();
        check("clr_objetivo", 16'(memoria), 16'd7);
        piso = 2'd1; puertas = 1'b1;
        n = 0;
        while (!(m_dwell && m_left == 1) && n < 20) begin step(); n++; end
        btn_subir = 3'b110; step();
        check("clr_pend", 16'(pendientes), 16'h100);
        check("clr_memoria", 16'(memoria), 16'd0);
        btn_subir = 3'b010; step();
        check("clr_sin_relatch", 16'(pendientes), 16'h100);
        check("clr_siguiente", 16'(memoria), 16'd9);
        btn_subir = 3'b000; piso = 2'd2;
        run_until_free("clr_servicio9");

        // en=0 for three cycles in the middle of the dwell
        puertas = 1'b0; piso = 2'd0; btn_cabina = 4'b1000; step();
        btn_cabina = 4'b0000; step();
        check("en_objetivo", 16'(memoria), 16'd4);
        piso = 2'd3; puertas = 1'b1; step(); step();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("en_memoria_congelada", 16'(memoria), 16'd4);
            check("en_ocupado_congelado", 16'(ocupado), 16'd1);
        end
        en = 1'b1;
        n = 0;
        while (ocupado && n < 10) begin step(); n++; end
        check("en_dwell_restante", 16'(n), 16'd3);

        // Button held through its own service is not re-latched until re-pressed
        puertas = 1'b0; piso = 2'd0; btn_cabina = 4'b0001; step(); step();
        check("hold_objetivo", 16'(memoria), 16'd1);
        puertas = 1'b1;
        run_until_free("hold_servicio");
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_pend_vacio", 16'(pendientes), 16'h000);
        end
        btn_cabina = 4'b0000; puertas = 1'b0; step();
        btn_cabina = 4'b0001; step();
        check("hold_repulsado", 16'(pendientes), 16'h001);
        btn_cabina = 4'b0000;

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 199) == 0);
            en         = ($urandom_range(0, 9) != 0);
            btn_cabina = 4'($urandom) & 4'($urandom) & 4'($urandom);
            btn_subir  = 3'($urandom) & 3'($urandom) & 3'($urandom);
            btn_bajar  = 3'($urandom) & 3'($urandom) & 3'($urandom);
            piso       = 2'($urandom_range(0, 3));
            puertas    = ($urandom_range(0, 2) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
